// File: rtl/pixel_pkg.sv
// Shared constants and state types for the single-pixel test system host link.
package pixel_pkg;

    // Host command bytes
    localparam logic [7:0] CMD_START = 8'h53;  // 'S'
    localparam logic [7:0] CMD_FRAME = 8'h46;  // 'F'

    // Argument bytes that may follow CMD_FRAME
    localparam logic [7:0] ARG_FRAME_100MS = 8'h30;  // '0'
    localparam logic [7:0] ARG_FRAME_1S    = 8'h31;  // '1'

    // Command parser states
    typedef enum logic {
        P_IDLE,
        P_ARG
    } parser_state_t;

    // Receive state machine states
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling state machine,
// registered byte output with one-cycle valid / framing-error pulses.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       Rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err
);
    import pixel_pkg::*;

    localparam int unsigned     CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_warm;   // becomes all-ones once the synchronizer holds real line samples
    logic             r_armed;  // line seen high since reset; a fresh falling edge may start a frame
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;

    logic w_rx;
    logic w_full_done;
    logic w_half_done;

    assign w_rx        = r_sync2;
    assign w_full_done = (r_cnt == FULL_LAST);
    assign w_half_done = (r_cnt == HALF_LAST);

    // Bring the asynchronous serial line into the clock domain
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_warm  <= 2'b00;
        end else begin
            r_sync1 <= Rx_in;
            r_sync2 <= r_sync1;
            r_warm  <= {r_warm[0], 1'b1};
        end
    end

    // Receive state machine with registered byte and status pulses
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit     <= 3'd0;
            r_shift   <= 8'h00;
            r_armed   <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    r_bit <= 3'd0;
                    if (!r_armed) begin
                        if (r_warm[1] && w_rx) begin
                            r_armed <= 1'b1;
                        end
                    end else if (!w_rx) begin
                        r_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (w_half_done) begin
                        r_cnt   <= '0;
                        r_state <= w_rx ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (w_full_done) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= RX_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (w_full_done) begin
                        r_cnt <= '0;
                        if (w_rx) begin
                            rx_data  <= r_shift;
                            rx_valid <= 1'b1;
                            r_state  <= RX_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= RX_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RX_BREAK: begin
                    // Hold off until the line returns high so a break is one error
                    if (w_rx) begin
                        r_state <= RX_IDLE;
                    end
                end
                default: begin
                    r_state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_cmd.sv
// Host UART receiver plus command decoder: 'S' requests a start, 'F' + '0'/'1'
// selects the frame time. Outputs mirror the front-panel control signals.
module uart_rx_cmd #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter logic [7:0]  CMD_START    = pixel_pkg::CMD_START,
    parameter logic [7:0]  CMD_FRAME    = pixel_pkg::CMD_FRAME
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       Rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       start_n,
    output logic       t_frame_sel,
    output logic       cmd_err
);
    import pixel_pkg::*;

    parser_state_t r_pstate;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .clk_in    (clk_in),
        .reset     (reset),
        .Rx_in     (Rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    // Command parser: decodes received bytes into start / frame-select controls
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_pstate    <= P_IDLE;
            start_n     <= 1'b1;
            t_frame_sel <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            start_n <= 1'b1;
            cmd_err <= 1'b0;
            case (r_pstate)
                P_IDLE: begin
                    // A framing error with no command pending is ignored here
                    if (rx_valid) begin
                        if (rx_data == CMD_START) begin
                            start_n <= 1'b0;
                        end else if (rx_data == CMD_FRAME) begin
                            r_pstate <= P_ARG;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                P_ARG: begin
                    if (rx_valid) begin
                        r_pstate <= P_IDLE;
                        if (rx_data == ARG_FRAME_100MS) begin
                            t_frame_sel <= 1'b0;
                        end else if (rx_data == ARG_FRAME_1S) begin
                            t_frame_sel <= 1'b1;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end else if (frame_err) begin
                        r_pstate <= P_IDLE;
                        cmd_err  <= 1'b1;
                    end
                end
                default: begin
                    r_pstate <= P_IDLE;
                end
            endcase
        end
    end

endmodule
